// File: rtl/sync_gen_pkg.sv
// Shared definitions for the sync generator: controller states, sel_reg field
// positions and the default minimum period.
package sync_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } sync_state_e;

  localparam int EN_BIT  = 31;
  localparam int ARM_BIT = 30;
  localparam int EXT_BIT = 29;
  localparam int PER_MSB = 23;

  localparam int DEFAULT_MIN_PERIOD = 2;

endpackage

// File: rtl/rise_detect.sv
// One-flop rising-edge detector: rise is high while d is 1 and was 0 last cycle.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= 1'b0;
    else     prev <= d;
  end

  assign rise = d & ~prev;

endmodule

// File: rtl/sync_period_ctrl.sv
// Sync-pulse period controller: free-running or externally aligned one-cycle
// pulses, with the period shadowed so changes only land on period boundaries.
module sync_period_ctrl
  import sync_gen_pkg::*;
#(
  parameter int MIN_PERIOD = DEFAULT_MIN_PERIOD,
  parameter int CNT_W      = 32
) (
  input  logic             user_clk,
  input  logic             user_rst,
  input  logic [31:0]      sel_reg,
  input  logic             ext_sync,
  output logic             sync_out,
  output logic [CNT_W-1:0] sync_count,
  output logic             running,
  output logic             armed,
  output logic             misaligned,
  output sync_state_e      state
);

  localparam logic [CNT_W-1:0] MIN_M1 = CNT_W'(MIN_PERIOD - 1);

  logic             enable, arm, ext_mode;
  logic [CNT_W-1:0] period_ext, eff_m1;
  logic [CNT_W-1:0] cnt, per_q;
  logic             arm_rise, ext_rise, at_wrap, fire;
  logic             unused_bits;

  assign enable      = sel_reg[EN_BIT];
  assign arm         = sel_reg[ARM_BIT];
  assign ext_mode    = sel_reg[EXT_BIT];
  assign period_ext  = CNT_W'(sel_reg[PER_MSB:0]);
  assign eff_m1      = (period_ext < MIN_M1) ? MIN_M1 : period_ext;
  assign unused_bits = ^sel_reg[EXT_BIT-1:PER_MSB+1];

  rise_detect u_arm_rise (
    .clk  (user_clk),
    .rst  (user_rst),
    .d    (arm),
    .rise (arm_rise)
  );

  rise_detect u_ext_rise (
    .clk  (user_clk),
    .rst  (user_rst),
    .d    (ext_sync),
    .rise (ext_rise)
  );

  assign at_wrap = (cnt == per_q);

  // A re-sync edge takes priority over the wrap or the external edge it coincides with.
  always_comb begin
    fire = 1'b0;
    if (enable) begin
      case (state)
        IDLE:    fire = ~ext_mode;
        ARMED:   fire = arm_rise ? ~ext_mode : ext_rise;
        RUN:     fire = arm_rise ? ~ext_mode : at_wrap;
        default: fire = 1'b0;
      endcase
    end
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      per_q      <= '0;
      sync_out   <= 1'b0;
      sync_count <= '0;
      misaligned <= 1'b0;
    end else begin
      sync_out <= fire;
      if (fire) begin
        sync_count <= sync_count + CNT_W'(1);
        per_q      <= eff_m1;
      end

      if (!enable) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (fire) begin
        state <= RUN;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            if (ext_mode) state <= ARMED;
          end
          ARMED: cnt <= '0;
          RUN: begin
            if (arm_rise) begin
              state <= ARMED;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end

      // An external edge landing exactly on the wrap counts as aligned.
      if (enable && arm_rise && state != IDLE)
        misaligned <= 1'b0;
      else if (state == RUN && ext_mode && ext_rise && !at_wrap)
        misaligned <= 1'b1;
    end
  end

  assign running = (state == RUN);
  assign armed   = (state == ARMED);

endmodule

// File: tb/tb_sync_period_ctrl.sv
// Bench for sync_period_ctrl: a pulse-schedule model checked every cycle, plus
// directed scenarios with hand-computed pulse times and counts.
module tb_sync_period_ctrl;
  import sync_gen_pkg::*;

  localparam int CNT_W      = 32;
  localparam int MIN_PERIOD = 2;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      sel_reg;
  logic             ext_sync;
  logic             sync_out;
  logic [CNT_W-1:0] sync_count;
  logic             running, armed, misaligned;
  sync_state_e      state;

  always #5 clk = ~clk;

  sync_period_ctrl #(.MIN_PERIOD(MIN_PERIOD), .CNT_W(CNT_W)) dut (
    .user_clk   (clk),
    .user_rst   (rst),
    .sel_reg    (sel_reg),
    .ext_sync   (ext_sync),
    .sync_out   (sync_out),
    .sync_count (sync_count),
    .running    (running),
    .armed      (armed),
    .misaligned (misaligned),
    .state      (state)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 waiting for external edge, 2 pulsing. phase counts cycles
  // since the last period start; len is the period latched at that start.
  int          m_mode, m_phase, m_len;
  bit          m_pulse, m_mis, m_prev_arm, m_prev_ext;
  logic [31:0] m_count;

  task automatic m_reset();
    m_mode = 0; m_phase = 0; m_len = 0; m_pulse = 0; m_mis = 0;
    m_prev_arm = 0; m_prev_ext = 0; m_count = '0;
  endtask

  task automatic m_start(input int per);
    m_mode  = 2;
    m_phase = 0;
    m_len   = ((per < MIN_PERIOD - 1) ? MIN_PERIOD - 1 : per) + 1;
    m_pulse = 1;
    m_count = m_count + 1;
  endtask

  task automatic m_step();
    bit en, arm, ext, arm_e, ext_e, at_b;
    int per;
    en    = sel_reg[31];
    arm   = sel_reg[30];
    ext   = sel_reg[29];
    per   = int'(sel_reg[23:0]);
    arm_e = arm && !m_prev_arm;
    ext_e = ext_sync && !m_prev_ext;
    m_prev_arm = arm;
    m_prev_ext = ext_sync;
    m_pulse = 0;
    at_b = (m_mode == 2) && (m_phase == m_len - 1);
    if (m_mode == 2 && ext && ext_e && !at_b && !(en && arm_e)) m_mis = 1;
    if (!en) begin
      m_mode = 0; m_phase = 0;
    end else if (m_mode == 0) begin
      if (!ext) m_start(per); else m_mode = 1;
    end else if (arm_e) begin
      m_mis = 0;
      if (!ext) m_start(per);
      else begin m_mode = 1; m_phase = 0; end
    end else if (m_mode == 1) begin
      if (ext_e) m_start(per);
    end else if (at_b) begin
      m_start(per);
    end else begin
      m_phase++;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else     m_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    sync_state_e exp_state;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        exp_state = (m_mode == 2) ? RUN : (m_mode == 1) ? ARMED : IDLE;
        check("m_sync_out",   32'(sync_out),   32'(m_pulse));
        check("m_sync_count", sync_count,      m_count);
        check("m_running",    32'(running),    32'(m_mode == 2));
        check("m_armed",      32'(armed),      32'(m_mode == 1));
        check("m_misaligned", 32'(misaligned), 32'(m_mis));
        check("m_state",      32'(state),      32'(exp_state));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ext_pulse();
    ext_sync = 1'b1;
    tick(1);
    ext_sync = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    rst = 1'b0; sel_reg = '0; ext_sync = 1'b0;
    #1 rst = 1'b1;
    chk_en = 1'b1;
    tick(2);
    @(negedge clk); #1 rst = 1'b0;
    tick(1);
    check("reset_count",   sync_count, 0);
    check("reset_running", 32'(running), 0);

    // Free-running, period 5
    sel_reg = 32'h8000_0004;
    tick(1); check("fr_first_pulse", 32'(sync_out), 1); check("fr_count1", sync_count, 1);
    check("fr_running", 32'(running), 1);
    tick(4); check("fr_gap", 32'(sync_out), 0);
    tick(1); check("fr_pulse2", 32'(sync_out), 1); check("fr_count2", sync_count, 2);
    tick(5); check("fr_pulse3", 32'(sync_out), 1);
    tick(5); check("fr_pulse4", 32'(sync_out), 1); check("fr_count4", sync_count, 4);

    // Clamped period, then a mid-period change lands at the boundary
    sel_reg = 32'h0;
    tick(2); check("dis_running", 32'(running), 0); check("dis_count_kept", sync_count, 4);
    sel_reg = 32'h8000_0000;
    tick(1); check("clamp_p1", 32'(sync_out), 1); check("clamp_c5", sync_count, 5);
    tick(1); check("clamp_gap", 32'(sync_out), 0);
    tick(1); check("clamp_p2", 32'(sync_out), 1);
    tick(1); sel_reg = 32'h8000_0009;
    tick(1); check("chg_old_period", 32'(sync_out), 1); check("chg_c7", sync_count, 7);
    tick(9); check("chg_gap", 32'(sync_out), 0);
    tick(1); check("chg_new_period", 32'(sync_out), 1); check("chg_c8", sync_count, 8);

    // External alignment, edges every 8 cycles
    sel_reg = 32'h0; tick(2);
    sel_reg = 32'hA000_0007;
    tick(1); check("ext_armed", 32'(armed), 1); check("ext_not_run", 32'(running), 0);
    tick(3); check("ext_wait", 32'(sync_out), 0);
    ext_pulse(); check("ext_p1", 32'(sync_out), 1); check("ext_c9", sync_count, 9);
    check("ext_disarmed", 32'(armed), 0);
    tick(7); ext_pulse(); check("ext_p2", 32'(sync_out), 1); check("ext_mis0", 32'(misaligned), 0);
    tick(7); ext_pulse(); check("ext_p3", 32'(sync_out), 1); check("ext_c11", sync_count, 11);

    // Shifted edge, then re-arm
    tick(4); ext_pulse(); check("shift_mis1", 32'(misaligned), 1); check("shift_nopulse", 32'(sync_out), 0);
    sel_reg = 32'hE000_0007;
    tick(1); check("rearm_mis0", 32'(misaligned), 0); check("rearm_armed", 32'(armed), 1);
    tick(2); ext_pulse(); check("rearm_pulse", 32'(sync_out), 1); check("rearm_c12", sync_count, 12);

    // Enable dropped on the wrap cycle
    sel_reg = 32'h0; tick(2);
    sel_reg = 32'h8000_0007;
    tick(1); check("drop_start", sync_count, 13);
    tick(7); sel_reg = 32'h0;
    tick(1); check("drop_nopulse", 32'(sync_out), 0); check("drop_c13", sync_count, 13);
    check("drop_idle", 32'(state), 32'(IDLE));

    // Arm and enable together from idle, then a free-running re-sync
    sel_reg = 32'hC000_0003;
    tick(1); check("armen_pulse", 32'(sync_out), 1); check("armen_c14", sync_count, 14);
    tick(3); check("armen_gap", 32'(sync_out), 0);
    tick(1); check("armen_p2", 32'(sync_out), 1);
    tick(1); sel_reg = 32'h8000_0003;
    tick(1); sel_reg = 32'hC000_0003;
    tick(1); check("resync_pulse", 32'(sync_out), 1); check("resync_c16", sync_count, 16);
    tick(3); check("resync_gap", 32'(sync_out), 0);
    tick(1); check("resync_p2", 32'(sync_out), 1); check("resync_c17", sync_count, 17);

    // Asynchronous reset mid-period with misaligned set
    sel_reg = 32'h0; tick(2);
    sel_reg = 32'hA000_0007;
    tick(1); ext_pulse(); check("rst_pre_c18", sync_count, 18);
    tick(2); ext_pulse(); check("rst_pre_mis", 32'(misaligned), 1);
    #2 rst = 1'b1;
    #1;
    check("rst_sync_out", 32'(sync_out), 0); check("rst_count", sync_count, 0);
    check("rst_running", 32'(running), 0); check("rst_mis", 32'(misaligned), 0);
    tick(1); sel_reg = 32'h8000_0007;
    @(negedge clk); #1 rst = 1'b0;
    tick(1); check("post_rst_pulse", 32'(sync_out), 1); check("post_rst_c1", sync_count, 1);
    check("post_rst_running", 32'(running), 1);
    tick(8); check("post_rst_p2", 32'(sync_out), 1);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
